// File: rtl/apb_s_pkg.sv
// apb_s_pkg: shared FSM state type, default parameter values and error-counter width for the APB slave
package apb_s_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACCESS} state_e;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int DEPTH_DEF = 16;
  localparam int WAIT_CYCLES_DEF = 0;
  localparam int ERR_W = 8;
endpackage

// File: rtl/apb_s_mem.sv
// apb_s_mem: DEPTH x DATA_W word store with byte-strobe write and asynchronous read
//   clk_i/rst_ni : clock, async active-low reset (clears every word)
//   we_i, waddr_i, wdata_i, wstrb_i : write port, only strobed byte lanes change
//   raddr_i -> rdata_o : combinational read port
module apb_s_mem #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 16,
  parameter int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mem_q <= '{default: '0};
    else if (we_i)
      for (int b = 0; b < DATA_W/8; b++)
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/apb_s_param.sv
// apb_s_param: parameterised APB slave with wait states, byte strobes, error response and error counter
//   pclk/presetn : clock, async active-low reset
//   psel, penable, pwrite, paddr (word index), pwdata, pstrb : APB request
//   prdata, pready, pslverr : APB response; err_cnt : saturating errored-transfer count
module apb_s_param import apb_s_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                pclk,
  input  logic                presetn,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr,
  output logic [ERR_W-1:0]    err_cnt
);
  localparam int SW = DATA_W/8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic wr_q;
  logic [DATA_W-1:0] wdata_q, lane_mask, rdata;
  logic [SW-1:0] strb_q;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic err;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (psel && !penable) ? SETUP : IDLE;
      SETUP:   state_d = !psel ? IDLE : penable ? ((WAIT_CYCLES > 0) ? WAIT : ACCESS) : SETUP;
      WAIT:    state_d = !psel ? IDLE : (cnt_q == CNT_LAST) ? ACCESS : WAIT;
      default: state_d = (psel && !penable) ? SETUP : IDLE;
    endcase
    cnt_d = (state_q == WAIT && state_d == WAIT) ? cnt_q + 4'd1 : 4'd0;
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      wr_q <= 1'b0;
      wdata_q <= '0;
      strb_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_cnt_q <= err_cnt_d;
      // request is re-sampled every SETUP cycle, so the value held is the one at the edge leaving SETUP
      if (state_q == SETUP) begin
        addr_q <= paddr;
        wr_q <= pwrite;
        wdata_q <= pwdata;
        strb_q <= pstrb;
      end
    end
  end
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < SW; i++) lane_mask[8*i +: 8] = {8{strb_q[i]}};
  end
  // X/Z checks reduce to X only in a 4-state simulator; they are constant false in hardware
  assign err = ({1'b0, addr_q} >= DEPTH_A) || ((^addr_q) === 1'bx) ||
               (wr_q && ((^(wdata_q & lane_mask)) === 1'bx));
  assign pready = (state_q == ACCESS);
  assign pslverr = pready && err;
  assign prdata = (pready && !err && !wr_q) ? rdata : '0;
  assign err_cnt_d = (pslverr && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
  assign err_cnt = err_cnt_q;
  apb_s_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_i(pclk),
    .rst_ni(presetn),
    .we_i(pready && !err && wr_q),
    .waddr_i(AW'(addr_q)),
    .wdata_i(wdata_q),
    .wstrb_i(strb_q),
    .raddr_i(AW'(addr_q)),
    .rdata_o(rdata)
  );
endmodule

// File: tb/tb_apb_s_param.sv
// tb_apb_s_param: directed self-checking bench for apb_s_param (DATA_W=32, DEPTH=16, WAIT_CYCLES=2)
module tb_apb_s_param;
  logic pclk = 1'b0, presetn = 1'b0, psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0] pstrb = '0;
  logic [31:0] prdata;
  logic pready, pslverr;
  logic [7:0] err_cnt;
  int checks = 0, fails = 0, lat;
  logic [31:0] rd;
  logic er, four_state, xt, any_rdy;

  apb_s_param #(.DATA_W(32), .ADDR_W(32), .DEPTH(16), .WAIT_CYCLES(2)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .err_cnt(err_cnt)
  );

  always #5 pclk = ~pclk;

  task automatic start(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1'b1;
  endtask

  task automatic finish(input bit scr);
    lat = 0; rd = '0; er = 1'b0;
    while (lat < 20) begin
      @(posedge pclk); #1;
      lat++;
      if (scr && lat == 1) begin
        paddr = paddr ^ 32'd1; pwdata = ~pwdata; pwrite = ~pwrite; pstrb = ~pstrb;
      end
      if (pready) begin
        rd = prdata; er = pslverr;
        break;
      end
    end
  endtask

  task automatic idle();
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
  endtask

  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    start(wr, a, d, s);
    finish(1'b0);
    idle();
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    checks++; if (pready !== 1'b0) begin fails++; $display("FAIL rst_pready got %b exp 0", pready); end
    checks++; if (pslverr !== 1'b0) begin fails++; $display("FAIL rst_pslverr got %b exp 0", pslverr); end
    checks++; if (prdata !== 32'd0) begin fails++; $display("FAIL rst_prdata got %h exp 0", prdata); end
    checks++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL rst_err_cnt got %0d exp 0", err_cnt); end
    presetn = 1'b1;
    start(1'b0, 32'd0, 32'd0, 4'h0);
    finish(1'b0);
    idle();
    checks++; if (lat !== 3) begin fails++; $display("FAIL first_setup_latency got %0d exp 3", lat); end
    checks++; if (rd !== 32'd0) begin fails++; $display("FAIL rst_mem0 got %h exp 0", rd); end
  endtask

  task automatic test_write_read();
    start(1'b1, 32'd3, 32'hDEADBEEF, 4'hF);
    finish(1'b0);
    idle();
    checks++; if (lat !== 3) begin fails++; $display("FAIL wr_latency got %0d exp 3", lat); end
    checks++; if (er !== 1'b0) begin fails++; $display("FAIL wr_pslverr got %b exp 0", er); end
    checks++; if (rd !== 32'd0) begin fails++; $display("FAIL wr_prdata got %h exp 0", rd); end
    start(1'b0, 32'd3, 32'd0, 4'h0);
    finish(1'b0);
    idle();
    checks++; if (lat !== 3) begin fails++; $display("FAIL rd_latency got %0d exp 3", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_addr3 got %h exp deadbeef", rd); end
    checks++; if (er !== 1'b0) begin fails++; $display("FAIL rd_pslverr got %b exp 0", er); end
    checks++; if (prdata !== 32'd0 || pready !== 1'b0) begin fails++; $display("FAIL idle_outputs got %h/%b exp 0/0", prdata, pready); end
  endtask

  task automatic test_strobe();
    xfer(1'b1, 32'd5, 32'hAABBCCDD, 4'hF);
    xfer(1'b1, 32'd5, 32'h12345678, 4'b0011);
    xfer(1'b0, 32'd5, 32'd0, 4'h0);
    checks++; if (rd !== 32'hAABB5678) begin fails++; $display("FAIL strobe_merge got %h exp aabb5678", rd); end
    xfer(1'b1, 32'd5, 32'hFFFFFFFF, 4'h0);
    checks++; if (er !== 1'b0) begin fails++; $display("FAIL strobe0_err got %b exp 0", er); end
    xfer(1'b0, 32'd5, 32'd0, 4'h0);
    checks++; if (rd !== 32'hAABB5678) begin fails++; $display("FAIL strobe0_nochange got %h exp aabb5678", rd); end
  endtask

  task automatic test_capture();
    start(1'b1, 32'd9, 32'h0F0F1234, 4'hF);
    finish(1'b1);
    idle();
    xfer(1'b0, 32'd9, 32'd0, 4'h0);
    checks++; if (rd !== 32'h0F0F1234) begin fails++; $display("FAIL capture_addr9 got %h exp 0f0f1234", rd); end
    xfer(1'b0, 32'd8, 32'd0, 4'h0);
    checks++; if (rd !== 32'd0) begin fails++; $display("FAIL capture_addr8 got %h exp 0", rd); end
  endtask

  task automatic test_idle_penable();
    xfer(1'b1, 32'd7, 32'h11111111, 4'hF);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'd7; pwdata = 32'd0; pstrb = 4'hF;
    any_rdy = 1'b0;
    repeat (5) begin @(posedge pclk); #1; any_rdy |= pready; end
    idle();
    checks++; if (any_rdy !== 1'b0) begin fails++; $display("FAIL no_setup_pready got %b exp 0", any_rdy); end
    xfer(1'b0, 32'd7, 32'd0, 4'h0);
    checks++; if (rd !== 32'h11111111) begin fails++; $display("FAIL no_setup_nowrite got %h exp 11111111", rd); end
  endtask

  task automatic test_abort();
    start(1'b1, 32'd7, 32'h22222222, 4'hF);
    @(posedge pclk); #1;
    any_rdy = pready;
    psel = 1'b0; penable = 1'b0;
    repeat (4) begin @(posedge pclk); #1; any_rdy |= pready; end
    checks++; if (any_rdy !== 1'b0) begin fails++; $display("FAIL abort_pready got %b exp 0", any_rdy); end
    xfer(1'b0, 32'd7, 32'd0, 4'h0);
    checks++; if (rd !== 32'h11111111) begin fails++; $display("FAIL abort_addr7 got %h exp 11111111", rd); end
  endtask

  task automatic test_back_to_back();
    start(1'b1, 32'd10, 32'hA0A0A0A0, 4'hF);
    finish(1'b0);
    start(1'b1, 32'd11, 32'hB1B1B1B1, 4'hF);
    finish(1'b0);
    idle();
    checks++; if (lat !== 3) begin fails++; $display("FAIL b2b_latency got %0d exp 3", lat); end
    xfer(1'b0, 32'd10, 32'd0, 4'h0);
    checks++; if (rd !== 32'hA0A0A0A0) begin fails++; $display("FAIL b2b_addr10 got %h exp a0a0a0a0", rd); end
    xfer(1'b0, 32'd11, 32'd0, 4'h0);
    checks++; if (rd !== 32'hB1B1B1B1) begin fails++; $display("FAIL b2b_addr11 got %h exp b1b1b1b1", rd); end
  endtask

  task automatic test_error();
    xfer(1'b1, 32'd20, 32'h99999999, 4'hF);
    checks++; if (er !== 1'b1) begin fails++; $display("FAIL err_wr20 got %b exp 1", er); end
    checks++; if (rd !== 32'd0) begin fails++; $display("FAIL err_wr20_prdata got %h exp 0", rd); end
    xfer(1'b0, 32'd16, 32'd0, 4'h0);
    checks++; if (er !== 1'b1) begin fails++; $display("FAIL err_rd16 got %b exp 1", er); end
    checks++; if (rd !== 32'd0) begin fails++; $display("FAIL err_rd16_prdata got %h exp 0", rd); end
    checks++; if (err_cnt !== 8'd2) begin fails++; $display("FAIL err_cnt got %0d exp 2", err_cnt); end
    checks++; if (pslverr !== 1'b0) begin fails++; $display("FAIL err_idle_pslverr got %b exp 0", pslverr); end
    xfer(1'b0, 32'd4, 32'd0, 4'h0);
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin fails++; $display("FAIL err_alias4 got %h/%b exp 0/0", rd, er); end
  endtask

  task automatic test_x();
    xt = 1'bx;
    four_state = (xt === 1'bx);
    xfer(1'b1, {28'd0, 4'bxx00}, 32'h55555555, 4'hF);
    if (four_state) begin
      checks++; if (er !== 1'b1) begin fails++; $display("FAIL x_addr_err got %b exp 1", er); end
    end
    xfer(1'b1, 32'd2, 32'hxx000000, 4'b1000);
    if (four_state) begin
      checks++; if (er !== 1'b1) begin fails++; $display("FAIL x_data_err got %b exp 1", er); end
      checks++; if (err_cnt !== 8'd4) begin fails++; $display("FAIL x_err_cnt got %0d exp 4", err_cnt); end
    end
    xfer(1'b1, 32'd2, 32'h000000xx, 4'b1110);
    if (four_state) begin
      checks++; if (er !== 1'b0) begin fails++; $display("FAIL x_masked_lane got %b exp 0", er); end
      xfer(1'b0, 32'd0, 32'd0, 4'h0);
      checks++; if (rd !== 32'd0) begin fails++; $display("FAIL x_addr0 got %h exp 0", rd); end
      xfer(1'b0, 32'd12, 32'd0, 4'h0);
      checks++; if (rd !== 32'd0) begin fails++; $display("FAIL x_addr12 got %h exp 0", rd); end
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 256; i++) xfer(1'b0, 32'd31, 32'd0, 4'h0);
    checks++; if (err_cnt !== 8'd255) begin fails++; $display("FAIL err_cnt_sat got %0d exp 255", err_cnt); end
  endtask

  task automatic test_reset_mid();
    start(1'b1, 32'd6, 32'hCAFEF00D, 4'hF);
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    checks++; if (pready !== 1'b0 || pslverr !== 1'b0) begin fails++; $display("FAIL mid_rst_resp got %b/%b exp 0/0", pready, pslverr); end
    checks++; if (prdata !== 32'd0) begin fails++; $display("FAIL mid_rst_prdata got %h exp 0", prdata); end
    checks++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL mid_rst_err_cnt got %0d exp 0", err_cnt); end
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    xfer(1'b0, 32'd6, 32'd0, 4'h0);
    checks++; if (rd !== 32'd0 || er !== 1'b0) begin fails++; $display("FAIL mid_rst_addr6 got %h/%b exp 0/0", rd, er); end
    xfer(1'b0, 32'd3, 32'd0, 4'h0);
    checks++; if (rd !== 32'd0) begin fails++; $display("FAIL mid_rst_addr3 got %h exp 0", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobe();
    test_capture();
    test_idle_penable();
    test_abort();
    test_back_to_back();
    test_error();
    test_x();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/apb_s_param.md
APB_S_PARAM -- requirements
Module: apb_s_param

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width in bits; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL have parameter ADDR_W, default 32, width of paddr.
REQ-003 SHALL have parameter DEPTH, default 16, number of DATA_W-bit words; legal range 2..1024.
REQ-004 SHALL have parameter WAIT_CYCLES, default 0, number of pready-low cycles inserted in each access phase; legal range 0..15.
REQ-005 SHALL have port pclk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port presetn, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port psel, input, 1 bit, slave select.
REQ-008 SHALL have port penable, input, 1 bit, access-phase strobe.
REQ-009 SHALL have port pwrite, input, 1 bit; 1 = write, 0 = read.
REQ-010 SHALL have port paddr, input, ADDR_W bits, word index (not a byte address).
REQ-011 SHALL have port pwdata, input, DATA_W bits, write data.
REQ-012 SHALL have port pstrb, input, DATA_W/8 bits, write byte lanes.
REQ-013 SHALL have port prdata, output, DATA_W bits, read data.
REQ-014 SHALL have port pready, output, 1 bit, transfer complete.
REQ-015 SHALL have port pslverr, output, 1 bit, transfer error.
REQ-016 SHALL have port err_cnt, output, 8 bits, saturating count of errored transfers.

Function
REQ-017 SHALL run an FSM with states IDLE, SETUP, WAIT and ACCESS.
- IDLE -> SETUP on psel=1 with penable=0.
- SETUP -> WAIT on penable=1 when WAIT_CYCLES>0, otherwise SETUP -> ACCESS.
- WAIT -> ACCESS after WAIT_CYCLES cycles.
- ACCESS -> SETUP if psel=1 and penable=0, otherwise ACCESS -> IDLE.
REQ-018 SHALL capture paddr, pwrite, pwdata and pstrb at the edge leaving SETUP, and ignore later changes to them within that transfer.
REQ-019 SHALL hold pready=0 in IDLE, SETUP and WAIT, and drive pready=1 for exactly one cycle in ACCESS; access-phase length is therefore WAIT_CYCLES+1 cycles.
REQ-020 SHALL flag an error when the captured paddr >= DEPTH, or when paddr contains any X/Z bit.
REQ-021 SHALL also flag an error on a write whose pwdata has any X/Z bit in an enabled byte lane; X/Z detection is simulation-only and evaluates false in synthesis.
REQ-022 SHALL drive pslverr=1 only while pready=1 on an errored transfer, and 0 at all other times.
REQ-023 SHALL commit a write only on the ACCESS edge with no error, updating only the byte lanes whose pstrb bit is 1; pstrb=0 produces no change and no error.
REQ-024 SHALL drive prdata with mem[paddr] while pready=1 on an error-free read, and drive prdata=0 at all other times, including errored reads and all writes.
REQ-025 SHALL increment err_cnt by 1 on every cycle where pready=1 and pslverr=1, and hold it at 255 once reached.
REQ-026 SHALL return to IDLE without writing and without asserting pready if psel falls in SETUP or WAIT.
REQ-027 SHALL stay in IDLE and ignore penable=1 when it is asserted without a preceding setup cycle.
REQ-028 SHALL accept back-to-back transfers, i.e. ACCESS followed directly by SETUP, with no idle cycle between them.

Reset
REQ-029 SHALL force, while presetn=0: state IDLE, pready=0, pslverr=0, prdata=0, err_cnt=0, WAIT counter 0, and every memory word 0.
REQ-030 SHALL abandon any in-flight transfer when reset is asserted in SETUP, WAIT or ACCESS, with no memory write.
REQ-031 SHALL recognise the first setup on the first rising edge after presetn deasserts.

Structure
REQ-032 SHALL take the FSM state enum, default parameter values and the err_cnt width from shared package apb_s_pkg.
REQ-033 SHALL implement storage, including the byte-strobe write and the read port, in sub-module apb_s_mem (parameters DATA_W, DEPTH); the FSM, error logic and counter stay in apb_s_param.

Verification (DATA_W=32, DEPTH=16, WAIT_CYCLES=2)
REQ-034 SHALL cover: write 0xDEADBEEF to addr 3 with pstrb=4'hF, then read addr 3 -> pready high 3 cycles after penable rises; prdata=0xDEADBEEF; pslverr=0.
REQ-035 SHALL cover: addr 5 holding 0xAABBCCDD, write 0x12345678 with pstrb=4'b0011, then read -> 0xAABB5678.
REQ-036 SHALL cover: write addr 20, then read addr 16 -> pslverr=1 on each; prdata=0; err_cnt=2; memory unchanged.
REQ-037 SHALL cover: write with paddr=4'bxx00, then write with an X in an enabled byte lane of pwdata -> pslverr=1 on each; no memory change.
REQ-038 SHALL cover: psel dropped in WAIT during a write to addr 7 -> pready never high; addr 7 reads back its old value.
REQ-039 SHALL cover: presetn pulsed low in WAIT during a write -> all outputs 0; err_cnt=0; target word remains 0.
